uart_rx_control: RTL and testbench
==================================

// Module: uart_rx_control
// PURPOSE
//  Receive-side frame controller for the PPG UART link; counterpart of the TX frame controller.
//  Takes bytes from the UART RX driver and hunts for a header byte:
//    8'hCC = display + record, 8'hC3 = display only.
//  Collects the 12 payload bytes that follow and reassembles them into one 96-bit word.
//  Presents the word with a ready/ack handshake. Sits between the UART RX driver and the command/record logic.
// PARAMETERS
//  TIMEOUT_CYC  50000  max sysClk cycles between payload bytes (1 ms @ 50 MHz); used only with UART_RX_TIMEOUT_EN
// PORTS
//  sysClk    in   1   system clock, 50 MHz
//  rst       in   1   reset, asynchronous, active-high
//  rxValid   in   1   one-cycle strobe: rxData holds a new byte
//  rxData    in   8   byte from the UART RX driver
//  rxErr     in   1   one-cycle strobe: framing/stop-bit error on the current byte
//  rdAck     in   1   consumer has read outdata; one-cycle pulse
//  outReady  out  1   outdata/data_rec hold a complete, unread frame
//  outdata   out  96  reassembled payload
//  data_rec  out  1   1 = header was 8'hCC (record), 0 = 8'hC3
//  overrun   out  1   one-cycle pulse: a completed frame was dropped because the previous one was unread
//  frameErr  out  1   one-cycle pulse: frame aborted (rxErr, or timeout when enabled)
// BEHAVIOUR
//  Clocking: one clock, sysClk. Reset is asynchronous, active-high.
//  Reset values:
//    - all outputs 0 (outReady=0, outdata=96'd0, data_rec=0, overrun=0, frameErr=0)
//    - state=HUNT, byteCnt=0
//  FSM
//    HUNT:
//      - rxValid with rxData==CC or C3: latch header type, byteCnt<=1, go PAYLOAD.
//      - any other byte is discarded.
//      - rxErr is ignored.
//    PAYLOAD:
//      - rxValid with rxErr=0: store the byte; byteCnt++.
//      - Header values inside the payload are data. No resync.
//      - rxErr: frameErr pulse, discard the partial frame, go HUNT.
//    On the 12th payload byte: go HUNT. The next cycle, either
//      - outdata/data_rec load and outReady=1 (latency 1 cycle after the last rxValid), or
//      - the frame is dropped with an overrun pulse.
//  Byte placement: payload byte k (k = 1..12), with g = (k-1)/3 and p = (k-1)%3,
//    goes to outdata[g*24 + (2-p)*8 +: 8].
//    Result: 24-bit groups in ascending order, each group MSB first.
//  Handshake
//    - rdAck while outReady=1: outReady=0 next cycle.
//    - rdAck while outReady=0: ignored.
//    - outdata and data_rec hold their values until a new frame loads.
//  Boundaries
//    - Frame completes while outReady=1 and no rdAck: new frame dropped, outdata unchanged, overrun pulse.
//    - Frame completes in the same cycle as rdAck: new frame loaded, outReady stays 1, no overrun.
//    - rxErr and rxValid together: treated as error.
//    - Reset mid-frame: partial frame discarded, state HUNT.
// CONFIGURATION
//  Macro UART_RX_TIMEOUT_EN
//    - Defined: an idle counter runs in PAYLOAD and clears on each rxValid.
//      When it reaches TIMEOUT_CYC: frameErr pulse, go HUNT.
//    - Undefined: no counter; PAYLOAD waits indefinitely and TIMEOUT_CYC is unused.
// STRUCTURE
//  Package uart_frame_pkg:
//    - HDR_REC = 8'hCC, HDR_DISP = 8'hC3, FRAME_BYTES = 12
//    - state encoding {HUNT, PAYLOAD}
//    - shared with the TX controller.
//  Sub-module uart_rx_timeout: idle counter with clear/enable/expire; instantiated only under UART_RX_TIMEOUT_EN.
// TESTING
//  1. Assert rst mid-frame -> all outputs 0; a complete frame sent after reset is accepted normally.
//  2. CC, then bytes 01..0C -> outReady=1 one cycle after the last byte.
//     outdata=96'h0A0B0C_070809_040506_010203, data_rec=1.
//  3. 00, 55, then C3 + 12 bytes -> leading bytes ignored; frame accepted with data_rec=0.
//  4. Two full frames, no rdAck -> first frame retained, one overrun pulse.
//     rdAck coincident with the 2nd frame's last byte -> 2nd frame loaded, no overrun.
//  5. rxErr on payload byte 6 -> frameErr pulse, outReady stays 0; the next clean frame is accepted.
//  6. UART_RX_TIMEOUT_EN with TIMEOUT_CYC=100: stall 101 cycles after byte 5 -> frameErr, back to HUNT.
//     Macro undefined: the same stall followed by the remaining bytes -> frame accepted.

Source files
------------

// File: rtl/uart_frame_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_frame_pkg : header codes, frame length and FSM states shared  |
// |                  by the UART RX and TX frame controllers.          |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
package uart_frame_pkg;

  localparam logic [7:0] HDR_REC     = 8'hCC;
  localparam logic [7:0] HDR_DISP    = 8'hC3;
  localparam int         FRAME_BYTES = 12;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } frame_state_t;

  // Bit offset of payload byte k (1-based): 24-bit groups ascending, MSB first in a group.
  function automatic logic [6:0] byte_lsb(input logic [3:0] k);
    int idx;
    idx = int'(k) - 1;
    return 7'(((idx / 3) * 24) + ((2 - (idx % 3)) * 8));
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_timeout.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_timeout : inter-byte idle counter, expires at TIMEOUT_CYC. |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module uart_rx_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [c_CNT_W-1:0] r_cnt;

  assign o_expire = i_en && !i_clr && (r_cnt == c_CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_control : hunts for a CC/C3 header, gathers 12 payload     |
// |   bytes into a 96-bit word, presents it with a ready/ack handshake.|
// |   Optional macro UART_RX_TIMEOUT_EN adds an inter-byte timeout.    |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module uart_rx_control #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        sysClk,
  input  logic        rst,
  input  logic        rxValid,
  input  logic [7:0]  rxData,
  input  logic        rxErr,
  input  logic        rdAck,
  output logic        outReady,
  output logic [95:0] outdata,
  output logic        data_rec,
  output logic        overrun,
  output logic        frameErr
);
  import uart_frame_pkg::*;

  frame_state_t r_state, w_stateNext;
  logic [3:0]   r_byteCnt, w_byteCntNext;
  logic         r_hdrRec, w_hdrRecNext;
  logic [95:0]  r_buf, w_bufNext;
  logic         w_store, w_complete, w_abort, w_timeout;

`ifdef UART_RX_TIMEOUT_EN
  uart_rx_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (sysClk),
    .rst      (rst),
    .i_en     (r_state == PAYLOAD),
    .i_clr    (rxValid),
    .o_expire (w_timeout)
  );
`else
  // No timeout in this build; the comparison is constant false.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    w_stateNext   = r_state;
    w_byteCntNext = r_byteCnt;
    w_hdrRecNext  = r_hdrRec;
    w_store       = 1'b0;
    w_complete    = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      HUNT: begin
        if (rxValid && !rxErr && (rxData == HDR_REC || rxData == HDR_DISP)) begin
          w_hdrRecNext  = (rxData == HDR_REC);
          w_byteCntNext = 4'd1;
          w_stateNext   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rxErr || w_timeout) begin
          w_abort       = 1'b1;
          w_byteCntNext = 4'd0;
          w_stateNext   = HUNT;
        end else if (rxValid) begin
          w_store = 1'b1;
          if (r_byteCnt == 4'(FRAME_BYTES)) begin
            w_complete    = 1'b1;
            w_byteCntNext = 4'd0;
            w_stateNext   = HUNT;
          end else begin
            w_byteCntNext = r_byteCnt + 4'd1;
          end
        end
      end
      default: begin
        w_byteCntNext = 4'd0;
        w_stateNext   = HUNT;
      end
    endcase
  end

  always_comb begin
    w_bufNext = r_buf;
    if (w_store) begin
      w_bufNext[byte_lsb(r_byteCnt) +: 8] = rxData;
    end
  end

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      r_state   <= HUNT;
      r_byteCnt <= 4'd0;
      r_hdrRec  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_byteCnt <= w_byteCntNext;
      r_hdrRec  <= w_hdrRecNext;
    end
  end

  // The completing byte is merged straight into outdata so outReady rises one cycle after it.
  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      r_buf    <= 96'd0;
      outReady <= 1'b0;
      outdata  <= 96'd0;
      data_rec <= 1'b0;
      overrun  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      r_buf    <= w_bufNext;
      overrun  <= 1'b0;
      frameErr <= w_abort;
      if (w_complete && (!outReady || rdAck)) begin
        outdata  <= w_bufNext;
        data_rec <= r_hdrRec;
        outReady <= 1'b1;
      end else begin
        if (w_complete) begin
          overrun <= 1'b1;
        end
        if (rdAck) begin
          outReady <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rx_control : directed and random byte streams checked      |
// |   against a frame-level reference model.                           |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_uart_rx_control;

  localparam int c_TO = 100;

  logic        sysClk = 1'b0;
  logic        rst;
  logic        rxValid, rxErr, rdAck;
  logic [7:0]  rxData;
  logic        outReady, data_rec, overrun, frameErr;
  logic [95:0] outdata;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_coll;
  int          m_n;
  int          m_idle;
  bit          m_rec;
  logic [7:0]  m_bytes [12];
  logic        exp_rdy, exp_rec, exp_ov, exp_fe;
  logic [95:0] exp_data;

  int ov_seen, fe_seen;

  always #5 sysClk = ~sysClk;

  uart_rx_control #(.TIMEOUT_CYC(c_TO)) dut (
    .sysClk   (sysClk),
    .rst      (rst),
    .rxValid  (rxValid),
    .rxData   (rxData),
    .rxErr    (rxErr),
    .rdAck    (rdAck),
    .outReady (outReady),
    .outdata  (outdata),
    .data_rec (data_rec),
    .overrun  (overrun),
    .frameErr (frameErr)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_outReady"}, 96'(outReady), 96'(exp_rdy));
    chk({pfx, "_outdata"},  outdata,       exp_data);
    chk({pfx, "_data_rec"}, 96'(data_rec), 96'(exp_rec));
    chk({pfx, "_overrun"},  96'(overrun),  96'(exp_ov));
    chk({pfx, "_frameErr"}, 96'(frameErr), 96'(exp_fe));
  endtask

  task automatic model_reset();
    m_coll = 0; m_n = 0; m_idle = 0; m_rec = 0;
    exp_rdy = 0; exp_rec = 0; exp_ov = 0; exp_fe = 0; exp_data = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic e, input logic a);
    bit done;
    done = 0; exp_ov = 0; exp_fe = 0;
    if (!m_coll) begin
      if (v && !e && (d == 8'hCC || d == 8'hC3)) begin
        m_coll = 1; m_rec = (d == 8'hCC); m_n = 0; m_idle = 0;
      end
    end else if (e) begin
      exp_fe = 1; m_coll = 0;
    end else if (v) begin
      m_bytes[m_n] = d; m_n++; m_idle = 0;
      if (m_n == 12) begin done = 1; m_coll = 0; end
    end else begin
      m_idle++;
`ifdef UART_RX_TIMEOUT_EN
      if (m_idle == c_TO + 1) begin exp_fe = 1; m_coll = 0; end
`endif
    end
    if (done) begin
      if (!exp_rdy || a) begin
        exp_rdy = 1; exp_rec = m_rec;
        for (int g = 0; g < 4; g++)
          exp_data[g*24 +: 24] = {m_bytes[3*g], m_bytes[3*g+1], m_bytes[3*g+2]};
      end else begin
        exp_ov = 1;
      end
    end else if (a) begin
      exp_rdy = 0;
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic e, input logic a);
    rxValid = v; rxData = d; rxErr = e; rdAck = a;
    @(posedge sysClk); #1;
    model_step(v, d, e, a);
    check_all("cyc");
    ov_seen += int'(overrun);
    fe_seen += int'(frameErr);
    rxValid = 0; rxErr = 0; rdAck = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] base, input logic ack_last);
    cyc(1, hdr, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, base + 8'(i), 0, (i == 11) ? ack_last : 1'b0);
  endtask

  task automatic do_reset();
    rxValid = 0; rxErr = 0; rdAck = 0; rxData = 8'h00;
    rst = 1; #2;
    model_reset();
    check_all("rst_async");
    @(posedge sysClk); #1;
    rst = 0;
    check_all("rst_hold");
  endtask

  initial begin
    rst = 1; rxValid = 0; rxErr = 0; rdAck = 0; rxData = 8'h00;
    model_reset();
    repeat (2) @(posedge sysClk);
    #1;
    check_all("reset");
    rst = 0;

    // basic record frame
    send_frame(8'hCC, 8'h01, 0);
    chk("t2_data", outdata, 96'h0A0B0C_070809_040506_010203);
    chk("t2_rec", 96'(data_rec), 96'd1);
    chk("t2_rdy", 96'(outReady), 96'd1);

    // reset in the middle of a frame
    cyc(1, 8'hCC, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
    do_reset();
    chk("t1_rdy", 96'(outReady), 96'd0);
    chk("t1_data", outdata, 96'd0);
    send_frame(8'hC3, 8'(($urandom)), 0);
    chk("t1_after_rdy", 96'(outReady), 96'd1);

    // leading junk, display-only header
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h00, 0, 0);
    cyc(1, 8'h55, 0, 0);
    send_frame(8'hC3, 8'h40, 0);
    chk("t3_rec", 96'(data_rec), 96'd0);
    chk("t3_rdy", 96'(outReady), 96'd1);

    // overrun, then completion coincident with rdAck
    ov_seen = 0;
    send_frame(8'hCC, 8'h70, 0);
    chk("t4_ov_count", 96'(ov_seen), 96'd1);
    chk("t4_kept", outdata[23:0], 96'h404142);
    ov_seen = 0;
    send_frame(8'hCC, 8'h90, 1);
    chk("t4_ack_ov", 96'(ov_seen), 96'd0);
    chk("t4_ack_data", outdata[23:0], 96'h909192);
    chk("t4_ack_rdy", 96'(outReady), 96'd1);

    // error on payload byte 6
    cyc(0, 8'h00, 0, 1);
    fe_seen = 0;
    cyc(1, 8'hCC, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'hA0 + 8'(i), 0, 0);
    cyc(1, 8'hA5, 1, 0);
    chk("t5_fe", 96'(fe_seen), 96'd1);
    chk("t5_rdy", 96'(outReady), 96'd0);
    send_frame(8'hC3, 8'hB0, 0);
    chk("t5_next_rdy", 96'(outReady), 96'd1);

    // 101-cycle stall after payload byte 5
    cyc(0, 8'h00, 0, 1);
    fe_seen = 0;
    cyc(1, 8'hCC, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'h01 + 8'(i), 0, 0);
    idle(c_TO + 1);
    for (int i = 5; i < 12; i++) cyc(1, 8'h01 + 8'(i), 0, 0);
`ifdef UART_RX_TIMEOUT_EN
    chk("t6_fe", 96'(fe_seen), 96'd1);
    chk("t6_rdy", 96'(outReady), 96'd0);
`else
    chk("t6_fe", 96'(fe_seen), 96'd0);
    chk("t6_rdy", 96'(outReady), 96'd1);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic       v, e, a;
      logic [7:0] d;
      int         r;
      r = int'($urandom_range(0, 7));
      v = ($urandom_range(0, 3) != 0);
      d = (r == 0) ? 8'hCC : (r == 1) ? 8'hC3 : 8'($urandom);
      e = m_coll && ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 5) == 0);
      cyc(v, d, e, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
